// File: rtl/instr_fetch_responder_pkg.sv
// Shared fault codes and response record for the instruction fetch responder.
package instr_fetch_responder_pkg;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  fault;
    } rsp_t;

endpackage

// File: rtl/instr_fetch_responder_if.sv
// Fetch request/response bus between the program counter (master) and the instruction store (slave).
interface instr_fetch_responder_if;

    // Both channels use valid/ready: a beat transfers on a rising edge where valid && ready; ready never depends on valid.
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
    logic        rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_fault
    );

endinterface

// File: rtl/instr_fetch_responder_resp_queue.sv
// Synchronous FIFO of fetch responses; the caller guarantees no push when full and no pop when empty.
module instr_fetch_responder_resp_queue
    import instr_fetch_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  rsp_t             i_push_data,
    input  logic             i_pop,
    output rsp_t             o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    rsp_t             r_store [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_store[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_head  = r_store[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction store with fixed read latency, fault flagging, an output queue for decode backpressure and a preload port.
module instr_fetch_responder
    import instr_fetch_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned QDEPTH      = 4,
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    instr_fetch_responder_if.slave bus,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [31:0]           load_data
);

    localparam int unsigned      CNT_W  = $clog2(QDEPTH + 1);
    localparam logic [31:0]      SPAN   = 32'(DEPTH_WORDS * 4);
    localparam logic [CNT_W:0]   QD_LIM = (CNT_W + 1)'(QDEPTH);

    logic [31:0]      r_mem [DEPTH_WORDS];
    rsp_t             r_pipe [LATENCY];
    logic [LATENCY-1:0] r_vld;
    logic [CNT_W-1:0] r_inflight;

    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_ready;
    logic             w_empty;
    logic             w_full;
    logic [CNT_W-1:0] w_qcount;
    logic [31:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_fault;
    rsp_t             w_new;
    rsp_t             w_head;

    // Every accepted request already owns a queue slot, so a pipeline result can never find the queue full.
    assign w_ready  = !w_full && (({1'b0, r_inflight} + {1'b0, w_qcount}) < QD_LIM);
    assign w_accept = bus.req_valid && w_ready;
    assign w_push   = r_vld[LATENCY-1];
    assign w_pop    = !w_empty && bus.rsp_ready;

    assign w_off = bus.req_addr - BASE_ADDR;
    assign w_idx = w_off[IDX_W+1:2];

    always_comb begin
        w_fault = FAULT_OK;
        if (bus.req_addr[1:0] != 2'b00) begin
            w_fault = FAULT_MISALIGN;
        end else if (w_off >= SPAN) begin
            w_fault = FAULT_RANGE;
        end
        w_new.addr  = bus.req_addr;
        w_new.fault = w_fault;
        w_new.data  = (w_fault == FAULT_OK) ? r_mem[w_idx] : 32'h0;
    end

    // The fetch reads before the preload write lands, so a same-edge fetch sees the old word.
    always_ff @(posedge CLK) begin
        if (load_en && (32'(load_idx) < DEPTH_WORDS)) begin
            r_mem[load_idx] <= load_data;
        end
    end

    always_ff @(posedge CLK) begin
        r_pipe[0] <= w_new;
        for (int i = 1; i < int'(LATENCY); i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_accept;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_inflight <= '0;
        end else if (w_accept && !w_push) begin
            r_inflight <= r_inflight + CNT_W'(1);
        end else if (w_push && !w_accept) begin
            r_inflight <= r_inflight - CNT_W'(1);
        end
    end

    instr_fetch_responder_resp_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .i_clk       (CLK),
        .i_rst_n     (RESET),
        .i_push      (w_push),
        .i_push_data (r_pipe[LATENCY-1]),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_qcount),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = !w_empty;
    assign bus.rsp_data  = w_empty ? 32'h0 : w_head.data;
    assign bus.rsp_addr  = w_empty ? 32'h0 : w_head.addr;
    assign bus.rsp_fault = w_empty ? FAULT_OK : w_head.fault;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Randomised and directed bench for instr_fetch_responder against a queue-based reference model.
module tb_instr_fetch_responder;

    localparam int LAT = 2;
    localparam int QD  = 4;
    localparam logic [31:0] A0 = 32'hA0A0_0000;
    localparam logic [31:0] A1 = 32'hA1A1_1111;
    localparam logic [31:0] A2 = 32'hA2A2_2222;
    localparam logic [31:0] A3 = 32'hA3A3_3333;

    logic        CLK;
    logic        RESET;
    logic        load_en;
    logic [7:0]  load_idx;
    logic [31:0] load_data;

    int n_checks = 0;
    int n_err    = 0;
    int edge_n   = 0;
    bit model_on = 1'b0;

    logic [31:0] mem_m [256];
    logic [65:0] exp_q [$];
    logic [65:0] pend_q [$];
    int          pend_due [$];

    logic [31:0] log_data [$];
    logic [31:0] log_addr [$];
    logic [1:0]  log_fault [$];
    int          log_edge [$];

    instr_fetch_responder_if u_if ();
    instr_fetch_responder_if u_ifb ();

    instr_fetch_responder #(
        .DEPTH_WORDS (256),
        .BASE_ADDR   (32'h0),
        .LATENCY     (LAT),
        .QDEPTH      (QD)
    ) u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .bus       (u_if),
        .load_en   (load_en),
        .load_idx  (load_idx),
        .load_data (load_data)
    );

    instr_fetch_responder #(
        .DEPTH_WORDS (256),
        .BASE_ADDR   (32'h0000_1000),
        .LATENCY     (LAT),
        .QDEPTH      (QD)
    ) u_dut_b (
        .CLK       (CLK),
        .RESET     (RESET),
        .bus       (u_ifb),
        .load_en   (load_en),
        .load_idx  (load_idx),
        .load_data (load_data)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_n <= edge_n + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Expected response for a fetch with BASE_ADDR 0 and 256 words: {addr, data, fault}.
    function automatic logic [65:0] model_rsp(input logic [31:0] a);
        logic [31:0] off;
        logic [1:0]  f;
        logic [31:0] d;
        off = a - 32'h0;
        d   = 32'h0;
        if ((a % 4) != 0) begin
            f = 2'd1;
        end else if (off >= 32'd1024) begin
            f = 2'd2;
        end else begin
            f = 2'd0;
            d = mem_m[off / 4];
        end
        return {a, d, f};
    endfunction

    // ---------------- reference model ----------------
    // Requests occupy a slot from acceptance until popped; each becomes visible LAT edges after acceptance.
    always @(posedge CLK) begin
        if (!RESET) begin
            pend_q.delete();
            pend_due.delete();
            exp_q.delete();
            model_on <= 1'b1;
        end else begin
            if (u_if.req_valid && (pend_q.size() + exp_q.size()) < QD) begin
                pend_q.push_back(model_rsp(u_if.req_addr));
                pend_due.push_back(edge_n + LAT);
            end
            if (exp_q.size() > 0 && u_if.rsp_ready) begin
                void'(exp_q.pop_front());
            end
            if (pend_due.size() > 0 && pend_due[0] == edge_n) begin
                exp_q.push_back(pend_q.pop_front());
                void'(pend_due.pop_front());
            end
        end
        if (load_en) begin
            mem_m[load_idx] <= load_data;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge CLK) begin
        if (model_on) begin
            check("req_ready", {31'b0, u_if.req_ready}, {31'b0, (pend_q.size() + exp_q.size()) < QD});
            check("rsp_valid", {31'b0, u_if.rsp_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                check("rsp_addr", u_if.rsp_addr, exp_q[0][65:34]);
                check("rsp_data", u_if.rsp_data, exp_q[0][33:2]);
                check("rsp_fault", {30'b0, u_if.rsp_fault}, {30'b0, exp_q[0][1:0]});
            end else begin
                check("idle_rsp_data", u_if.rsp_data, 32'h0);
                check("idle_rsp_addr", u_if.rsp_addr, 32'h0);
            end
        end
    end

    // Log of every completed response handshake on the main DUT.
    always @(posedge CLK) begin
        if (RESET && u_if.rsp_valid && u_if.rsp_ready) begin
            log_data.push_back(u_if.rsp_data);
            log_addr.push_back(u_if.rsp_addr);
            log_fault.push_back(u_if.rsp_fault);
            log_edge.push_back(edge_n);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic log_clear();
        log_data.delete();
        log_addr.delete();
        log_fault.delete();
        log_edge.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic fetch_a(input logic [31:0] a, output int acc_edge);
        int guard = 0;
        acc_edge = -1;
        u_if.req_valid = 1'b1;
        u_if.req_addr  = a;
        forever begin
            @(posedge CLK);
            if (u_if.req_ready) begin
                acc_edge = edge_n;
                break;
            end
            guard++;
            if (guard > 50) begin
                n_checks++;
                n_err++;
                $display("FAIL accept_timeout: addr 0x%08h never accepted", a);
                break;
            end
        end
        @(negedge CLK);
        u_if.req_valid = 1'b0;
    endtask

    task automatic fetch_b(input logic [31:0] a, output logic [31:0] d, output logic [1:0] f);
        int guard = 0;
        d = 32'hFFFF_FFFF;
        f = 2'b11;
        u_ifb.req_valid = 1'b1;
        u_ifb.req_addr  = a;
        @(posedge CLK);
        @(negedge CLK);
        u_ifb.req_valid = 1'b0;
        while (!u_ifb.rsp_valid && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        n_checks++;
        if (!u_ifb.rsp_valid) begin
            n_err++;
            $display("FAIL b_rsp_timeout: no response for 0x%08h", a);
        end else begin
            d = u_ifb.rsp_data;
            f = u_ifb.rsp_fault;
            @(negedge CLK);
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        n_checks++;
        if (log_data.size() < n) begin
            n_err++;
            $display("FAIL log_wait: got %0d responses, want %0d", log_data.size(), n);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) return 32'($urandom_range(0, 255)) << 2;
        if (k == 6) return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        if (k == 7) return 32'd1024 + (32'($urandom_range(0, 63)) << 2);
        if (k == 8) return 32'd1020 + 32'($urandom_range(0, 8));
        return $urandom();
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int acc0;
        int tmp;
        int n_acc;
        int rdy_pct;
        logic [31:0] bd;
        logic [1:0]  bf;

        RESET           = 1'b0;
        load_en         = 1'b0;
        load_idx        = 8'd0;
        load_data       = 32'h0;
        u_if.req_valid  = 1'b0;
        u_if.req_addr   = 32'h0;
        u_if.rsp_ready  = 1'b0;
        u_ifb.req_valid = 1'b0;
        u_ifb.req_addr  = 32'h0;
        u_ifb.rsp_ready = 1'b1;

        // Preload while held in reset.
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            load_en   = 1'b1;
            load_idx  = 8'(i);
            load_data = (i == 0) ? A0 : (i == 1) ? A1 : (i == 2) ? A2 : (i == 3) ? A3 : $urandom();
        end
        @(negedge CLK);
        load_en = 1'b0;
        check("reset_req_ready", {31'b0, u_if.req_ready}, 32'd1);
        check("reset_rsp_valid", {31'b0, u_if.rsp_valid}, 32'd0);
        check("reset_rsp_data", u_if.rsp_data, 32'h0);
        check("reset_rsp_fault", {30'b0, u_if.rsp_fault}, 32'd0);
        RESET          = 1'b1;
        u_if.rsp_ready = 1'b1;
        @(negedge CLK);

        // Back-to-back aligned fetches.
        log_clear();
        fetch_a(32'd0, acc0);
        fetch_a(32'd4, tmp);
        fetch_a(32'd8, tmp);
        fetch_a(32'd12, tmp);
        wait_log(4, 20);
        if (log_data.size() >= 4) begin
            // Visible after edge acc0+2, taken by the consumer at the following edge.
            check("b2b_first_edge", 32'(log_edge[0]), 32'(acc0 + 3));
            check("b2b_d0", log_data[0], A0);
            check("b2b_d1", log_data[1], A1);
            check("b2b_d2", log_data[2], A2);
            check("b2b_d3", log_data[3], A3);
            check("b2b_consecutive", 32'(log_edge[3] - log_edge[0]), 32'd3);
            check("b2b_fault", {30'b0, log_fault[3]}, 32'd0);
        end

        // Non-zero base: below-base wraps out of range, base maps to word 0.
        fetch_b(32'h0000_0FFC, bd, bf);
        check("base_below_fault", {30'b0, bf}, 32'd2);
        check("base_below_data", bd, 32'h0);
        fetch_b(32'h0000_1000, bd, bf);
        check("base_w0_fault", {30'b0, bf}, 32'd0);
        check("base_w0_data", bd, A0);
        fetch_b(32'h0000_1400, bd, bf);
        check("base_end_fault", {30'b0, bf}, 32'd2);

        // Fault decode.
        log_clear();
        fetch_a(32'd6, tmp);
        fetch_a(32'd1024, tmp);
        fetch_a(32'd1026, tmp);
        wait_log(3, 20);
        if (log_data.size() >= 3) begin
            check("mis_fault", {30'b0, log_fault[0]}, 32'd1);
            check("mis_data", log_data[0], 32'h0);
            check("mis_addr", log_addr[0], 32'd6);
            check("range_fault", {30'b0, log_fault[1]}, 32'd2);
            check("range_addr", log_addr[1], 32'd1024);
            check("prio_fault", {30'b0, log_fault[2]}, 32'd1);
        end

        // Backpressure: exactly QD requests fit.
        u_if.rsp_ready = 1'b0;
        n_acc          = 0;
        u_if.req_valid = 1'b1;
        u_if.req_addr  = 32'd16;
        repeat (10) begin
            @(posedge CLK);
            if (u_if.req_ready) n_acc++;
            @(negedge CLK);
            u_if.req_addr = 32'(16 + 4 * n_acc);
        end
        u_if.req_valid = 1'b0;
        check("bp_accepts", 32'(n_acc), 32'd4);
        check("bp_ready_low", {31'b0, u_if.req_ready}, 32'd0);
        log_clear();
        u_if.rsp_ready = 1'b1;
        repeat (8) @(negedge CLK);
        check("bp_count", 32'(log_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_data.size(); i++) begin
            check("bp_order_addr", log_addr[i], 32'(16 + 4 * i));
            check("bp_order_data", log_data[i], mem_m[4 + i]);
        end
        check("bp_ready_high", {31'b0, u_if.req_ready}, 32'd1);

        // Same-edge preload and fetch: old word, then new word.
        log_clear();
        load_en        = 1'b1;
        load_idx       = 8'd2;
        load_data      = 32'h0000_DEAD;
        u_if.req_valid = 1'b1;
        u_if.req_addr  = 32'd8;
        @(posedge CLK);
        @(negedge CLK);
        load_en = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        u_if.req_valid = 1'b0;
        wait_log(2, 20);
        if (log_data.size() >= 2) begin
            check("rbw_old", log_data[0], A2);
            check("rbw_new", log_data[1], 32'h0000_DEAD);
        end

        // Reset with two in flight and two queued.
        u_if.rsp_ready = 1'b0;
        fetch_a(32'd0, tmp);
        fetch_a(32'd4, tmp);
        fetch_a(32'd8, tmp);
        fetch_a(32'd12, tmp);
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("midrst_rsp_valid", {31'b0, u_if.rsp_valid}, 32'd0);
        check("midrst_req_ready", {31'b0, u_if.req_ready}, 32'd1);
        RESET          = 1'b1;
        u_if.rsp_ready = 1'b1;
        log_clear();
        fetch_a(32'd0, tmp);
        wait_log(1, 20);
        repeat (6) @(negedge CLK);
        check("midrst_count", 32'(log_data.size()), 32'd1);
        if (log_data.size() >= 1) check("midrst_data", log_data[0], A0);

        // Randomised traffic in phases of differing consumer readiness.
        for (int p = 0; p < 8; p++) begin
            rdy_pct = $urandom_range(10, 100);
            repeat (250) begin
                @(negedge CLK);
                RESET          = ($urandom_range(0, 149) != 0);
                u_if.req_valid = ($urandom_range(0, 9) < 7);
                u_if.req_addr  = rand_addr();
                u_if.rsp_ready = ($urandom_range(1, 100) <= rdy_pct);
                load_en        = ($urandom_range(0, 9) == 0);
                load_idx       = 8'($urandom_range(0, 255));
                load_data      = $urandom();
            end
        end
        @(negedge CLK);
        RESET          = 1'b1;
        u_if.req_valid = 1'b0;
        u_if.rsp_ready = 1'b1;
        load_en        = 1'b0;
        repeat (12) @(negedge CLK);
        check("drain_rsp_valid", {31'b0, u_if.rsp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Memory-side end of the instruction fetch interface: accepts fetch addresses issued by the program counter and returns instruction words.
- Fixed read latency, plus an output queue so the decode stage can apply backpressure.
- Flags misaligned and out-of-range fetches.
- Includes a preload port so the bench or boot logic can fill the instruction store.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words stored.
- BASE_ADDR, 32'h0, byte address of word 0.
- LATENCY, 2, cycles from an accepted request to its entry in the output queue (minimum 1).
- QDEPTH, 4, output queue entries (must be at least LATENCY+1 for full throughput).

Ports:
- CLK, input, 1, clock; all state updates on the rising edge. The PC updates on the falling edge, so req_addr is stable at the rising edge.
- RESET, input, 1, reset; synchronous, active-low.
- req_valid, input, 1, fetch request present.
- req_addr, input, 32, fetch byte address.
- req_ready, output, 1, responder can accept a request this cycle.
- rsp_valid, output, 1, head of the output queue is valid.
- rsp_data, output, 32, instruction word.
- rsp_addr, output, 32, echo of the request address.
- rsp_fault, output, 2, 00 ok, 01 misaligned, 10 out of range.
- rsp_ready, input, 1, consumer takes the response.
- load_en, input, 1, preload write strobe.
- load_idx, input, clog2(DEPTH_WORDS), word index to write.
- load_data, input, 32, word to write.

Behaviour:
- Reset (RESET==0 at a rising edge):
  - Clears the pipeline valid bits, queue pointers, queue count and in-flight count.
  - Outputs after reset: rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_fault=00, req_ready=1.
  - Memory contents are not cleared.
  - Reset mid-operation discards all in-flight and queued responses; nothing is emitted afterwards for them.
- Accept rule:
  - A request is accepted when req_valid && req_ready at a rising edge.
  - req_ready = (inflight + qcount) < QDEPTH; it is combinational from registered counts only, with no path from req_valid.
- Fault decode happens in the accept cycle:
  - off = req_addr - BASE_ADDR, computed in 32 bits.
  - Misaligned if req_addr[1:0] != 0.
  - Out of range if off >= DEPTH_WORDS*4, unsigned compare. An address below BASE_ADDR wraps to a large offset and is therefore out of range.
  - Misaligned has priority over out of range.
  - A faulted request still occupies a slot and returns rsp_data=0.
- Latency pipeline:
  - The word read happens at accept; the result travels through LATENCY-1 further register stages.
  - It is written into the queue at the end of cycle LATENCY after accept.
  - With an empty queue, rsp_valid rises LATENCY cycles after the accepting edge.
  - Back-to-back requests give one response per cycle.
- Queue:
  - FIFO order; responses are never reordered.
  - rsp_* show the head entry; the head is popped on rsp_valid && rsp_ready.
  - Full: req_ready=0 guarantees a pipeline result always has space, so no drop case exists.
  - Simultaneous push and pop leaves qcount unchanged.
  - Pointers wrap modulo QDEPTH.
- Counters:
  - inflight increments on accept and decrements on push.
  - qcount increments on push and decrements on pop.
  - Simultaneous increment and decrement on the same counter leaves it unchanged.
- Preload:
  - load_en writes mem[load_idx] at the rising edge.
  - A same-cycle fetch of the same word returns the old data (read-before-write).
  - load_idx >= DEPTH_WORDS is ignored.
  - Preload is allowed at any time, including during reset.

Decomposition:
- Shared package holds:
  - Fault code constants FAULT_OK=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10.
  - The response struct {addr, data, fault}.
- One sub-module is natural: resp_queue (a parameterised synchronous FIFO with push, pop, count, full and empty).
- The pipeline and fault decode stay in the top module.

Test Plan:
- Preload mem[0..3]=A0,A1,A2,A3; reset; issue addr 0,4,8,12 back-to-back with rsp_ready=1 -> rsp_valid first at edge 2 after the first accept, then data A0..A3 on consecutive cycles with rsp_fault=00.
- Issue addr 6 -> rsp_fault=01, rsp_data=0, rsp_addr=6. Issue addr 1024 (DEPTH 256) -> rsp_fault=10. Issue addr 1026 -> rsp_fault=01 (misaligned priority).
- Hold rsp_ready=0 and stream requests -> exactly 4 accepted, then req_ready=0. Release rsp_ready -> 4 responses in order, then req_ready=1.
- Same edge: load_en, idx 2, data 0xDEAD, plus fetch addr 8 where old word=A2 -> response A2. A following fetch of 8 -> 0xDEAD.
- Assert RESET=0 with 2 in flight and 2 queued -> next cycle rsp_valid=0, req_ready=1. After release, a new fetch of addr 0 returns A0 with no stale responses.
- BASE_ADDR=32'h1000: fetch 0x0FFC -> fault 10; fetch 0x1000 -> mem[0].
